// File: rtl/cmp_pkg.sv
// Shared types and constants for the bit-serial magnitude comparator.
// Holds the FSM state enum, cascade init constants and the counter-width helper.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } cmp_state_t;

    // Running flags start as "equal so far, not greater".
    localparam logic E_INIT = 1'b1;
    localparam logic G_INIT = 1'b0;

    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/cmp_bit_slice.sv
// One-bit equal/greater cascade cell used by the serial comparator.
// Ports: ai/bi bit pair, e_in/g_in running flags, msb_first scan order; e_out/g_out updated flags.
module cmp_bit_slice (
    input  logic ai,
    input  logic bi,
    input  logic e_in,
    input  logic g_in,
    input  logic msb_first,
    output logic e_out,
    output logic g_out
);

    logic same;

    always_comb begin
        same  = ~(ai ^ bi);
        e_out = e_in & same;
        if (msb_first) begin
            // First differing bit decides; later bits cannot change it.
            g_out = g_in | (e_in & ai & ~bi);
        end else begin
            // A differing higher bit overrides whatever lower bits said.
            g_out = (ai & ~bi) | (same & g_in);
        end
    end

endmodule

// File: rtl/serial_mag_comparator.sv
// Bit-serial unsigned magnitude comparator: one bit pair per clock through one cascade cell.
// Ports: clk, rst (sync, active-high), in_valid/in_ready, a, b; busy, done pulse, eq/gt/lt flags.
module serial_mag_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    cmp_state_t       state_q, state_d;
    logic [WIDTH-1:0] shift_a_q, shift_a_d;
    logic [WIDTH-1:0] shift_b_q, shift_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             e_run_q, e_run_d;
    logic             g_run_q, g_run_d;
    logic             eq_q, eq_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;

    logic ai, bi, e_nxt, g_nxt, accept;

    assign ai = (LSB_FIRST != 0) ? shift_a_q[0] : shift_a_q[WIDTH-1];
    assign bi = (LSB_FIRST != 0) ? shift_b_q[0] : shift_b_q[WIDTH-1];

    cmp_bit_slice u_slice (
        .ai        (ai),
        .bi        (bi),
        .e_in      (e_run_q),
        .g_in      (g_run_q),
        .msb_first (LSB_FIRST == 0),
        .e_out     (e_nxt),
        .g_out     (g_nxt)
    );

    assign in_ready = (state_q != SHIFT);
    assign busy     = (state_q == SHIFT);
    assign done     = (state_q == DONE);
    assign eq       = eq_q;
    assign gt       = gt_q;
    assign lt       = lt_q;
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d   = state_q;
        shift_a_d = shift_a_q;
        shift_b_d = shift_b_q;
        cnt_d     = cnt_q;
        e_run_d   = e_run_q;
        g_run_d   = g_run_q;
        eq_d      = eq_q;
        gt_d      = gt_q;
        lt_d      = lt_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    shift_a_d = a;
                    shift_b_d = b;
                    e_run_d   = E_INIT;
                    g_run_d   = G_INIT;
                    cnt_d     = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (LSB_FIRST != 0) begin
                    shift_a_d = {1'b0, shift_a_q[WIDTH-1:1]};
                    shift_b_d = {1'b0, shift_b_q[WIDTH-1:1]};
                end else begin
                    shift_a_d = {shift_a_q[WIDTH-2:0], 1'b0};
                    shift_b_d = {shift_b_q[WIDTH-2:0], 1'b0};
                end
                e_run_d = e_nxt;
                g_run_d = g_nxt;
                if (cnt_q == LAST) begin
                    // Counter parks at the last index rather than wrapping.
                    eq_d    = e_nxt;
                    gt_d    = g_nxt;
                    lt_d    = ~e_nxt & ~g_nxt;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_a_q <= '0;
            shift_b_q <= '0;
            cnt_q     <= '0;
            e_run_q   <= 1'b0;
            g_run_q   <= 1'b0;
            eq_q      <= 1'b0;
            gt_q      <= 1'b0;
            lt_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_a_q <= shift_a_d;
            shift_b_q <= shift_b_d;
            cnt_q     <= cnt_d;
            e_run_q   <= e_run_d;
            g_run_q   <= g_run_d;
            eq_q      <= eq_d;
            gt_q      <= gt_d;
            lt_q      <= lt_d;
        end
    end

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Testbench for serial_mag_comparator: MSB-first and LSB-first instances, WIDTH=8.
// Expected flags are queued at acceptance and popped by a monitor on each done pulse.
module tb_serial_mag_comparator;

    logic            clk = 1'b0;
    logic [1:0]      rst;
    logic [1:0]      iv;
    logic [1:0][7:0] av;
    logic [1:0][7:0] bv;
    logic [1:0]      rdy, bsy, dn, eqv, gtv, ltv;

    logic [2:0] sb0[$];
    logic [2:0] sb1[$];
    logic [2:0] mon_exp;
    int         nvec = 0;
    int         miss = 0;

    always #5 clk = ~clk;

    serial_mag_comparator #(.WIDTH(8), .LSB_FIRST(0)) dut_msb (
        .clk (clk), .rst (rst[0]), .in_valid (iv[0]), .in_ready (rdy[0]),
        .a (av[0]), .b (bv[0]), .busy (bsy[0]), .done (dn[0]),
        .eq (eqv[0]), .gt (gtv[0]), .lt (ltv[0])
    );

    serial_mag_comparator #(.WIDTH(8), .LSB_FIRST(1)) dut_lsb (
        .clk (clk), .rst (rst[1]), .in_valid (iv[1]), .in_ready (rdy[1]),
        .a (av[1]), .b (bv[1]), .busy (bsy[1]), .done (dn[1]),
        .eq (eqv[1]), .gt (gtv[1]), .lt (ltv[1])
    );

    // Scoreboard monitor: every done pulse pops and checks one expectation.
    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (!rst[s] && dn[s]) begin
                nvec++;
                if ((s == 0 ? sb0.size() : sb1.size()) == 0) begin
                    miss++;
                    $display("FAIL sb%0d_unexpected_done flags=%b", s, {eqv[s], gtv[s], ltv[s]});
                end else begin
                    mon_exp = (s == 0) ? sb0.pop_front() : sb1.pop_front();
                    if ({eqv[s], gtv[s], ltv[s]} !== mon_exp) begin
                        miss++;
                        $display("FAIL sb%0d_flags eq/gt/lt got=%b want=%b",
                                 s, {eqv[s], gtv[s], ltv[s]}, mon_exp);
                    end
                end
            end
        end
    end

    // Drive one operand pair at the current negedge; return at the next negedge.
    task automatic accept(input int sel, input logic [7:0] a, input logic [7:0] b,
                          input bit hold);
        logic [2:0] e;
        e = {a == b, a > b, a < b};
        av[sel] = a;
        bv[sel] = b;
        iv[sel] = 1'b1;
        if (sel == 0) sb0.push_back(e);
        else sb1.push_back(e);
        @(negedge clk);
        if (!hold) iv[sel] = 1'b0;
    endtask

    task automatic wait_done(input int sel, output int cyc);
        cyc = 0;
        while (!dn[sel] && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 2'b11;
        iv  = 2'b00;
        av  = '0;
        bv  = '0;
        repeat (2) @(negedge clk);
        rst = 2'b00;
        for (int s = 0; s < 2; s++) begin
            nvec++;
            if ({rdy[s], bsy[s], dn[s], eqv[s], gtv[s], ltv[s]} !== 6'b100000) begin
                miss++;
                $display("FAIL reset%0d rdy/busy/done/eq/gt/lt got=%b want=100000", s,
                         {rdy[s], bsy[s], dn[s], eqv[s], gtv[s], ltv[s]});
            end
        end
    endtask

    task automatic run_one(input int sel, input logic [7:0] a, input logic [7:0] b,
                           input string name);
        int cyc;
        @(negedge clk);
        accept(sel, a, b, 1'b0);
        nvec++;
        if ({bsy[sel], rdy[sel], dn[sel]} !== 3'b100) begin
            miss++;
            $display("FAIL %s_start busy/rdy/done got=%b want=100", name,
                     {bsy[sel], rdy[sel], dn[sel]});
        end
        wait_done(sel, cyc);
        nvec++;
        if (cyc !== 8) begin
            miss++;
            $display("FAIL %s_latency got=%0d want=8", name, cyc);
        end
    endtask

    task automatic test_msb();
        run_one(0, 8'h5A, 8'h5A, "msb_eq");
        run_one(0, 8'h80, 8'h7F, "msb_gt");
        run_one(0, 8'h01, 8'h02, "msb_lt");
        run_one(0, 8'h7F, 8'h80, "msb_lt_top");
    endtask

    task automatic test_lsb();
        run_one(1, 8'h12, 8'h21, "lsb_lt");
        run_one(1, 8'hF0, 8'h0F, "lsb_gt");
        run_one(1, 8'h00, 8'h00, "lsb_eq");
        run_one(1, 8'h81, 8'h80, "lsb_gt_low");
    endtask

    task automatic test_ignore_valid();
        int cyc;
        @(negedge clk);
        accept(0, 8'h33, 8'h33, 1'b1);
        av[0] = 8'hFF;
        bv[0] = 8'h00;
        cyc = 0;
        while (!dn[0] && cyc < 50) begin
            nvec++;
            if (rdy[0] !== 1'b0 || bsy[0] !== 1'b1) begin
                miss++;
                $display("FAIL ign_shift_rdy rdy/busy got=%b want=01", {rdy[0], bsy[0]});
            end
            @(negedge clk);
            cyc++;
        end
        iv[0] = 1'b0;
        nvec++;
        if (cyc !== 8) begin
            miss++;
            $display("FAIL ign_latency got=%0d want=8", cyc);
        end
        @(negedge clk);
        nvec++;
        if ({bsy[0], dn[0], rdy[0]} !== 3'b001) begin
            miss++;
            $display("FAIL ign_after busy/done/rdy got=%b want=001", {bsy[0], dn[0], rdy[0]});
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        run_one(0, 8'h40, 8'h30, "b2b_first");
        accept(0, 8'h10, 8'h20, 1'b0);
        nvec++;
        if ({bsy[0], eqv[0], gtv[0], ltv[0]} !== 4'b1010) begin
            miss++;
            $display("FAIL b2b_hold busy/eq/gt/lt got=%b want=1010",
                     {bsy[0], eqv[0], gtv[0], ltv[0]});
        end
        repeat (4) @(negedge clk);
        nvec++;
        if ({eqv[0], gtv[0], ltv[0]} !== 3'b010) begin
            miss++;
            $display("FAIL b2b_hold_mid eq/gt/lt got=%b want=010", {eqv[0], gtv[0], ltv[0]});
        end
        wait_done(0, cyc);
        nvec++;
        if (cyc !== 4) begin
            miss++;
            $display("FAIL b2b_gap got=%0d want=9", cyc + 5);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        accept(0, 8'h00, 8'hFF, 1'b0);
        repeat (4) @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        sb0.delete();
        nvec++;
        if ({rdy[0], bsy[0], dn[0], eqv[0], gtv[0], ltv[0]} !== 6'b100000) begin
            miss++;
            $display("FAIL rst_mid rdy/busy/done/eq/gt/lt got=%b want=100000",
                     {rdy[0], bsy[0], dn[0], eqv[0], gtv[0], ltv[0]});
        end
        repeat (3) @(negedge clk);
        nvec++;
        if ({bsy[0], dn[0]} !== 2'b00) begin
            miss++;
            $display("FAIL rst_mid_idle busy/done got=%b want=00", {bsy[0], dn[0]});
        end
        run_one(0, 8'hC3, 8'hC3, "rst_fresh");
    endtask

    initial begin
        test_reset();
        test_msb();
        test_lsb();
        test_ignore_valid();
        test_back_to_back();
        test_reset_mid();
        repeat (3) @(negedge clk);
        nvec++;
        if (sb0.size() + sb1.size() !== 0) begin
            miss++;
            $display("FAIL sb_leftover got=%0d want=0", sb0.size() + sb1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, miss);
        $finish;
    end

endmodule
